series_adder_frame_packer: RTL and testbench
============================================

# series_adder_frame_packer

Upstream stage of `series_adder_data_streamer`. Accepts a stream of 32-bit words, one per cycle, on a valid/ready input, and assembles them into M-word frames. Each complete frame is issued to the streamer as a packed `data_i` vector with a one-cycle `data_vld` pulse, timed by the streamer's `data_rdy`. The block is double-buffered, so the next frame fills while the current frame is pending or being summed.

## Interface
- `M`, 8: words per frame; must be 2 or more.
- `W`, 32: word width; the streamer input expects 32.
- `CNT_W`, 16: width of `frame_cnt`.

- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_p`  in  1: synchronous, active-high reset.
- `s_data`  in  W: input word.
- `s_valid`  in  1: `s_data` is valid.
- `s_last`  in  1: marks the final word of a frame; may arrive early, producing a short frame.
- `s_ready`  out  1: packer can accept a word this cycle.
- `data_o`  out  M*W: packed frame. Word k sits at `[W*k+W-1 : W*k]`; the first accepted word is k=0. Connects to the streamer's `data_i`.
- `data_vld`  out  1: one-cycle issue pulse to the streamer.
- `data_rdy`  in  1: streamer is idle.
- `frame_cnt`  out  CNT_W: number of frames issued; wraps modulo 2^CNT_W.
- `short_frame`  out  1: the most recently issued frame was zero-padded.

## Operation
- A word is accepted at any rising edge where `s_valid & s_ready`.
- **Fill buffer**
  - Holds M word registers, a word index `fill_idx` (0..M-1) and a `fill_full` flag.
  - Each accepted word is written at `fill_idx`.
  - The frame closes when the accepted word has `fill_idx==M-1` or `s_last=1`.
  - A frame closing on `s_last` with `fill_idx<M-1` is short. Words `fill_idx+1..M-1` are forced to 0, and a `short` tag is stored with the frame.
  - `s_last` on word M-1 closes a normal frame. Reaching word M-1 without `s_last` also closes a normal frame; this is not an error.
  - When a frame closes, `fill_idx` returns to 0.
- **Output buffer** state machine, driving `data_o`:
  - EMPTY: nothing pending.
  - PEND: holding a frame, waiting for `data_rdy`.
  - SENT: `data_vld` is high for exactly this one cycle.
- **Transfers**
  - The output buffer loads a closed frame when its state is EMPTY or SENT. The streamer captures `data_i` on the `data_vld` cycle, so SENT is free to be overwritten.
  - The load happens at the same edge the last word is accepted if the output buffer is free then; otherwise the fill buffer holds the frame with `fill_full=1`.
- **State transitions**
  - PEND → SENT at an edge with `data_rdy=1`. At that edge `frame_cnt` increments and `short_frame` takes the frame's tag.
  - SENT → PEND if a load occurs at that edge, otherwise SENT → EMPTY.
  - EMPTY → PEND on a load.
  - `data_rdy` is ignored in SENT, which acts as a guard cycle while the streamer's registered `data_rdy` falls.
- **Backpressure:** `s_ready = !fill_full`. When a held frame moves to the output buffer, `fill_full` clears at the same edge.
- `data_o` is stable from load until the next load. Bits are never partially updated.
- **Reset**
  - The fill buffer is cleared and `fill_idx=0`.
  - Output state is EMPTY, `data_o=0`, `data_vld=0`, `frame_cnt=0`, `short_frame=0`.
  - `s_ready` is 1 in the first cycle after reset.
  - Reset mid-frame discards the partial frame, and any frame still pending is never issued.

## Timing
- All outputs are registered except `s_ready`, which is combinational from `fill_full` only (no input-to-output path).
- Minimum latency: last word accepted at edge t with the output buffer free and `data_rdy=1` → `data_vld` high in the cycle after edge t+1.
- Back-to-back operation: a new frame can load while SENT. The next `data_vld` is then gated only by the streamer returning `data_rdy=1`.
- Sustained input: 1 word/cycle while the streamer keeps up. Once two frames are buffered, `s_ready` drops until the output buffer frees.
- Simultaneous events at one edge:
  - Closing word accepted while the state is SENT → load proceeds; the state goes to PEND.
  - `s_last` arrives on the first word (`fill_idx=0`) → a 1-word short frame, words 1..M-1 = 0.

## Test plan
- **Full frame:** reset, stream words 1..8 (M=8) with `data_rdy=1` → exactly one `data_vld` pulse with `data_o` words 1..8, `short_frame=0`, `frame_cnt=1`.
- **Short frame:** stream 5,6,7 with `s_last` on 7 → `data_o` words {5,6,7,0,0,0,0,0}, `short_frame=1`. The next full frame clears `short_frame`.
- **Backpressure:** hold `data_rdy=0` and stream 24 words → two frames are buffered and `s_ready=0` from the 17th word. Raise `data_rdy` → frame A issues, `s_ready` returns to 1, frame B issues after `data_rdy` drops and rises again.
- **Latency:** last word accepted at edge t with `data_rdy=1` → `data_vld` high after edge t+1, exactly one cycle wide. `data_o` is unchanged until the next load.
- **Reset mid-frame:** 3 words accepted, then `rst_p` pulsed → no `data_vld`. The next 8 words form frame 1 starting at word 0, with `frame_cnt=1`.
- **Counter wrap:** with CNT_W=4, issue 17 frames → `frame_cnt` reads 1.

Source files
------------

// File: rtl/series_adder_frame_packer.sv
// Double-buffered packer: collects W-bit words into M-word frames and hands each
// frame to the series adder streamer as one packed vector with a single-cycle valid pulse.
module series_adder_frame_packer #(
  parameter int M     = 8,
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [M*W-1:0]   data_o,
  output logic             data_vld,
  input  logic             data_rdy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             short_frame
);

  localparam int IDX_W = $clog2(M);

  typedef enum logic [1:0] {EMPTY, PEND, SENT} outState_e;

  logic [W-1:0]     fillWords_q [M];
  logic [IDX_W-1:0] fillIdx_q;
  logic             fillFull_q;
  logic             fillShort_q;

  outState_e        outState_q;
  logic [M*W-1:0]   data_q;
  logic             outShort_q;
  logic             dataVld_q;
  logic [CNT_W-1:0] frameCnt_q;
  logic             shortFrame_q;

  logic             accept;
  logic             atLastIdx;
  logic             closeNow;
  logic             outFree;
  logic             loadHeld;
  logic             load;
  logic [M*W-1:0]   frame_d;
  logic             frameShort_d;

  assign s_ready   = !fillFull_q;
  assign accept    = s_valid & s_ready;
  assign atLastIdx = (fillIdx_q == IDX_W'(M - 1));
  assign closeNow  = accept & (atLastIdx | s_last);
  // SENT counts as free: the streamer has already captured data_o on the pulse cycle.
  assign outFree   = (outState_q != PEND);
  assign loadHeld  = fillFull_q & outFree;
  assign load      = loadHeld | (closeNow & outFree);

  // The frame as it would look if loaded now: either the held frame or the
  // frame being closed by the current word, with words past it zero-padded.
  always_comb begin
    frame_d = '0;
    for (int k = 0; k < M; k++) begin
      if (fillFull_q) begin
        frame_d[W*k +: W] = fillWords_q[k];
      end else if (k < int'(fillIdx_q)) begin
        frame_d[W*k +: W] = fillWords_q[k];
      end else if (k == int'(fillIdx_q)) begin
        frame_d[W*k +: W] = s_data;
      end
    end
    frameShort_d = fillFull_q ? fillShort_q : (s_last & !atLastIdx);
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      for (int k = 0; k < M; k++) begin
        fillWords_q[k] <= '0;
      end
      fillIdx_q   <= '0;
      fillFull_q  <= 1'b0;
      fillShort_q <= 1'b0;
    end else begin
      if (loadHeld) begin
        fillFull_q <= 1'b0;
      end
      if (accept) begin
        if (closeNow) begin
          fillIdx_q <= '0;
          if (!outFree) begin
            for (int k = 0; k < M; k++) begin
              fillWords_q[k] <= frame_d[W*k +: W];
            end
            fillFull_q  <= 1'b1;
            fillShort_q <= frameShort_d;
          end
        end else begin
          fillWords_q[fillIdx_q] <= s_data;
          fillIdx_q              <= fillIdx_q + IDX_W'(1);
        end
      end
    end
  end

  // Output buffer; data_rdy is deliberately ignored in SENT as a guard cycle.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      outState_q   <= EMPTY;
      data_q       <= '0;
      outShort_q   <= 1'b0;
      dataVld_q    <= 1'b0;
      frameCnt_q   <= '0;
      shortFrame_q <= 1'b0;
    end else begin
      dataVld_q <= 1'b0;
      if (load) begin
        data_q     <= frame_d;
        outShort_q <= frameShort_d;
      end
      unique case (outState_q)
        EMPTY: begin
          if (load) outState_q <= PEND;
        end
        PEND: begin
          if (data_rdy) begin
            outState_q   <= SENT;
            dataVld_q    <= 1'b1;
            frameCnt_q   <= frameCnt_q + CNT_W'(1);
            shortFrame_q <= outShort_q;
          end
        end
        SENT: begin
          outState_q <= load ? PEND : EMPTY;
        end
        default: outState_q <= EMPTY;
      endcase
    end
  end

  assign data_o      = data_q;
  assign data_vld    = dataVld_q;
  assign frame_cnt   = frameCnt_q;
  assign short_frame = shortFrame_q;

endmodule

// File: tb/tb_series_adder_frame_packer.sv
// Self-checking bench for series_adder_frame_packer: table-driven frames plus
// directed latency, backpressure, mid-frame reset and counter-wrap sequences.
module tb_series_adder_frame_packer;

  localparam int M     = 8;
  localparam int W     = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_p;
  logic [W-1:0]     s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [M*W-1:0]   data_o;
  logic             data_vld;
  logic             data_rdy;
  logic [CNT_W-1:0] frame_cnt;
  logic             short_frame;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] expCnt = '0;

  series_adder_frame_packer #(.M(M), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_p(rst_p), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .data_o(data_o), .data_vld(data_vld), .data_rdy(data_rdy),
    .frame_cnt(frame_cnt), .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [31:0] base;
    logic        lastOnFull;
    logic        expShort;
  } vec_t;

  function automatic logic [M*W-1:0] makeFrame(input int len, input logic [31:0] base);
    logic [M*W-1:0] v = '0;
    for (int k = 0; k < len; k++) v[W*k +: W] = base + 32'(k);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [M*W-1:0] act, input logic [M*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one word at a negedge once s_ready is seen high; returns after the accepting edge.
  task automatic applyStimulus(input logic [31:0] d, input logic last);
    int guard = 0;
    @(negedge clk);
    s_valid = 1'b0;
    while (!s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!s_ready) begin
      errors++;
      $display("[TB] FAIL s_ready wait: got 0 expected 1");
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(posedge clk);
  endtask

  task automatic waitVld(input string name);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    while (!data_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    expCnt++;
    checkOutput({name, " vld seen"}, M*W'(data_vld), M*W'(1));
  endtask

  task automatic checkFrame(input string name, input logic [M*W-1:0] expData, input logic expShort);
    waitVld(name);
    checkOutput({name, " data"}, data_o, expData);
    checkOutput({name, " short"}, M*W'(short_frame), M*W'(expShort));
    checkOutput({name, " cnt"}, M*W'(frame_cnt), M*W'(expCnt));
    @(negedge clk);
    checkOutput({name, " vld width"}, M*W'(data_vld), '0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " s_ready"}, M*W'(s_ready), M*W'(1));
    checkOutput({name, " data_o"}, data_o, '0);
    checkOutput({name, " vld"}, M*W'(data_vld), '0);
    checkOutput({name, " cnt"}, M*W'(frame_cnt), '0);
    checkOutput({name, " short"}, M*W'(short_frame), '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [6];
    logic [M*W-1:0] frameA;
    logic [M*W-1:0] frameB;
    logic sawVld;

    vecs[0] = '{len: 8, base: 32'd1,          lastOnFull: 1'b0, expShort: 1'b0};
    vecs[1] = '{len: 3, base: 32'd5,          lastOnFull: 1'b1, expShort: 1'b1};
    vecs[2] = '{len: 8, base: 32'h0000_0100,  lastOnFull: 1'b1, expShort: 1'b0};
    vecs[3] = '{len: 1, base: 32'hAAAA_0000,  lastOnFull: 1'b1, expShort: 1'b1};
    vecs[4] = '{len: 7, base: 32'h0000_0020,  lastOnFull: 1'b1, expShort: 1'b1};
    vecs[5] = '{len: 8, base: 32'hFFFF_FFF8,  lastOnFull: 1'b0, expShort: 1'b0};

    rst_p = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; data_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
    checkResetState("reset");
    data_rdy = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].len; k++) begin
        applyStimulus(vecs[i].base + 32'(k),
                      (k == vecs[i].len - 1) && (vecs[i].len < M || vecs[i].lastOnFull));
      end
      checkFrame($sformatf("vec%0d", i), makeFrame(vecs[i].len, vecs[i].base), vecs[i].expShort);
    end

    // Minimum latency and data_o hold after the pulse
    for (int k = 0; k < M; k++) applyStimulus(32'h0000_0040 + 32'(k), k == M - 1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("lat t+0 vld", M*W'(data_vld), '0);
    @(negedge clk);
    expCnt++;
    checkOutput("lat t+1 vld", M*W'(data_vld), M*W'(1));
    checkOutput("lat data", data_o, makeFrame(8, 32'h40));
    checkOutput("lat cnt", M*W'(frame_cnt), M*W'(expCnt));
    @(negedge clk);
    checkOutput("lat t+2 vld", M*W'(data_vld), '0);
    repeat (2) @(negedge clk);
    checkOutput("lat data hold", data_o, makeFrame(8, 32'h40));

    // Backpressure: two frames buffered, third word stream stalls
    data_rdy = 1'b0;
    for (int k = 0; k < 2*M; k++) applyStimulus(32'd1 + 32'(k), 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'd17; s_last = 1'b0;
    checkOutput("bp ready low", M*W'(s_ready), '0);
    sawVld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sawVld = sawVld | data_vld | s_ready;
    end
    checkOutput("bp stalled", M*W'(sawVld), '0);
    data_rdy = 1'b1;
    frameA = makeFrame(8, 32'd1);
    frameB = makeFrame(8, 32'd9);
    @(negedge clk);
    expCnt++;
    checkOutput("bp A vld", M*W'(data_vld), M*W'(1));
    checkOutput("bp A data", data_o, frameA);
    checkOutput("bp A ready", M*W'(s_ready), '0);
    checkOutput("bp A cnt", M*W'(frame_cnt), M*W'(expCnt));
    data_rdy = 1'b0;
    @(negedge clk);
    checkOutput("bp ready back", M*W'(s_ready), M*W'(1));
    checkOutput("bp B loaded", data_o, frameB);
    checkOutput("bp B no vld", M*W'(data_vld), '0);
    for (int k = 18; k <= 24; k++) applyStimulus(32'(k), 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    data_rdy = 1'b1;
    checkFrame("bp B", frameB, 1'b0);
    checkFrame("bp C", makeFrame(8, 32'd17), 1'b0);

    // Reset with a pending frame and a partial frame: neither may issue
    data_rdy = 1'b0;
    for (int k = 0; k < M; k++) applyStimulus(32'h0000_0200 + 32'(k), 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(32'h0000_0280 + 32'(k), 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_p = 1'b1;
    @(negedge clk);
    rst_p = 1'b0;
    expCnt = '0;
    checkResetState("mid reset");
    data_rdy = 1'b1;
    sawVld = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sawVld = sawVld | data_vld;
    end
    checkOutput("mid reset no vld", M*W'(sawVld), '0);
    for (int k = 0; k < M; k++) applyStimulus(32'h0000_0300 + 32'(k), 1'b0);
    checkFrame("post reset", makeFrame(8, 32'h300), 1'b0);

    // Counter wrap with a 4-bit counter: 17 frames reads back 1
    @(negedge clk);
    rst_p = 1'b1;
    @(negedge clk);
    rst_p = 1'b0;
    expCnt = '0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(32'h0000_0500 + 32'(i), 1'b1);
      checkFrame($sformatf("wrap%0d", i), makeFrame(1, 32'h500 + 32'(i)), 1'b1);
    end
    checkOutput("wrap final cnt", M*W'(frame_cnt), M*W'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
